// File: rtl/sap1_controller_sequencer_pkg.sv
// Shared SAP-1 definitions: opcodes, T-state encodings and control-word bit positions.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // State code equals the T-state number so o_state can be read directly.
  typedef enum logic [2:0] {
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    HALT = 3'd7
  } state_t;

  localparam int CW_CP = 0;
  localparam int CW_EP = 1;
  localparam int CW_LM = 2;
  localparam int CW_CE = 3;
  localparam int CW_LI = 4;
  localparam int CW_EI = 5;
  localparam int CW_LA = 6;
  localparam int CW_EA = 7;
  localparam int CW_SU = 8;
  localparam int CW_EU = 9;
  localparam int CW_LB = 10;
  localparam int CW_LO = 11;
  localparam int CW_W  = 12;

  typedef logic [CW_W-1:0] cw_t;

  function automatic cw_t cw_bit(input int idx);
    cw_t w;
    w      = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// Controller <-> datapath bundle: run/opcode/debug in, enables and status out.
interface sap1_ctrl_if;
  logic       i_debug;
  logic       i_run;
  logic [3:0] i_opcode;
  logic       o_cp, o_ep, o_lm, o_ce, o_li, o_ei;
  logic       o_la, o_ea, o_su, o_eu, o_lb, o_lo;
  logic [2:0] o_state;
  logic       o_halted;
  logic       o_instr_done;

  modport master (
    input  i_debug, i_run, i_opcode,
    output o_cp, o_ep, o_lm, o_ce, o_li, o_ei,
           o_la, o_ea, o_su, o_eu, o_lb, o_lo,
           o_state, o_halted, o_instr_done
  );

  modport slave (
    output i_debug, i_run, i_opcode,
    input  o_cp, o_ep, o_lm, o_ce, o_li, o_ei,
           o_la, o_ea, o_su, o_eu, o_lb, o_lo,
           o_state, o_halted, o_instr_done
  );
endinterface

// File: rtl/sap1_controller_sequencer_ring.sv
// T-state ring: T1 waits on run, T4 traps HLT into HALT, only reset leaves HALT.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic [3:0] i_opcode,
  output state_t     o_state
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_state <= T1;
    end else begin
      unique case (o_state)
        T1:      if (i_run) o_state <= T2;
        T2:      o_state <= T3;
        T3:      o_state <= T4;
        T4:      o_state <= (i_opcode == OP_HLT) ? HALT : T5;
        T5:      o_state <= T6;
        T6:      o_state <= T1;
        HALT:    o_state <= HALT;
        default: o_state <= T1;
      endcase
    end
  end

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control sequencer: decodes (T-state, opcode) into the per-cycle control word.
module sap1_controller_sequencer
  import sap1_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  sap1_ctrl_if.master bus
);

  state_t state;
  cw_t    cw;

  sap1_ring_counter u_ring (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_run    (bus.i_run),
    .i_opcode (bus.i_opcode),
    .o_state  (state)
  );

  // Reset gates the word so an abandoned instruction cannot touch the datapath.
  always_comb begin
    cw = '0;
    if (!i_reset) begin
      unique case (state)
        T1: if (bus.i_run) cw = cw_bit(CW_EP) | cw_bit(CW_LM);
        T2: cw = cw_bit(CW_CP);
        T3: cw = cw_bit(CW_CE) | cw_bit(CW_LI);
        T4: begin
          unique case (bus.i_opcode)
            OP_LDA, OP_ADD, OP_SUB: cw = cw_bit(CW_EI) | cw_bit(CW_LM);
            OP_OUT:                 cw = cw_bit(CW_EA) | cw_bit(CW_LO);
            default:                cw = '0;
          endcase
        end
        T5: begin
          unique case (bus.i_opcode)
            OP_LDA:         cw = cw_bit(CW_CE) | cw_bit(CW_LA);
            OP_ADD, OP_SUB: cw = cw_bit(CW_CE) | cw_bit(CW_LB);
            default:        cw = '0;
          endcase
        end
        T6: begin
          unique case (bus.i_opcode)
            OP_ADD:  cw = cw_bit(CW_EU) | cw_bit(CW_LA);
            OP_SUB:  cw = cw_bit(CW_EU) | cw_bit(CW_LA) | cw_bit(CW_SU);
            default: cw = '0;
          endcase
        end
        default: cw = '0;
      endcase
    end
  end

  assign bus.o_cp = cw[CW_CP];
  assign bus.o_ep = cw[CW_EP];
  assign bus.o_lm = cw[CW_LM];
  assign bus.o_ce = cw[CW_CE];
  assign bus.o_li = cw[CW_LI];
  assign bus.o_ei = cw[CW_EI];
  assign bus.o_la = cw[CW_LA];
  assign bus.o_ea = cw[CW_EA];
  assign bus.o_su = cw[CW_SU];
  assign bus.o_eu = cw[CW_EU];
  assign bus.o_lb = cw[CW_LB];
  assign bus.o_lo = cw[CW_LO];

  assign bus.o_state      = state;
  assign bus.o_halted     = (state == HALT);
  // HLT never reaches T6, so T6 alone marks a completed instruction.
  assign bus.o_instr_done = !i_reset && (state == T6);

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed + random bench against a step-counting micro-program model of the SAP-1 sequencer.
module tb_sap1_controller_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sap1_ctrl_if bus ();

  sap1_controller_sequencer dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Enable masks, MSB first: cp ep lm ce li ei la ea su eu lb lo
  localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200, M_CE = 12'h100;
  localparam logic [11:0] M_LI = 12'h080, M_EI = 12'h040, M_LA = 12'h020, M_EA = 12'h010;
  localparam logic [11:0] M_SU = 12'h008, M_EU = 12'h004, M_LB = 12'h002, M_LO = 12'h001;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which step (1..6) of the current instruction we are in, plus a halt flag.
  int m_step;
  bit m_halt;

  function automatic logic [11:0] micro(int step, logic [3:0] op, bit run);
    logic [11:0] m;
    m = 12'h000;
    case (step)
      1: m = run ? (M_EP | M_LM) : 12'h000;
      2: m = M_CP;
      3: m = M_CE | M_LI;
      4: if (op == 4'h0 || op == 4'h1 || op == 4'h2) m = M_EI | M_LM;
         else if (op == 4'hE) m = M_EA | M_LO;
      5: if (op == 4'h0) m = M_CE | M_LA;
         else if (op == 4'h1 || op == 4'h2) m = M_CE | M_LB;
      6: if (op == 4'h1) m = M_EU | M_LA;
         else if (op == 4'h2) m = M_EU | M_LA | M_SU;
      default: m = 12'h000;
    endcase
    return m;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance one clock and the model with it.
  task automatic cyc();
    logic [11:0] got_cw, exp_cw;
    int          drivers;
    @(negedge clk);
    got_cw = {bus.o_cp, bus.o_ep, bus.o_lm, bus.o_ce, bus.o_li, bus.o_ei,
              bus.o_la, bus.o_ea, bus.o_su, bus.o_eu, bus.o_lb, bus.o_lo};
    exp_cw = (rst || m_halt) ? 12'h000 : micro(m_step, bus.i_opcode, bus.i_run);
    drivers = int'(bus.o_ep) + int'(bus.o_ce) + int'(bus.o_ei) + int'(bus.o_ea) + int'(bus.o_eu);
    chk("cw", {4'h0, got_cw}, {4'h0, exp_cw});
    chk("state", {13'h0, bus.o_state}, m_halt ? 16'd7 : 16'(m_step));
    chk("halted", {15'h0, bus.o_halted}, {15'h0, m_halt});
    chk("done", {15'h0, bus.o_instr_done}, {15'h0, (!rst && !m_halt && m_step == 6)});
    chk("bus_excl", {15'h0, (drivers <= 1)}, 16'h1);
    @(posedge clk);
    if (rst) begin
      m_step = 1;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_step == 1) m_step = bus.i_run ? 2 : 1;
      else if (m_step == 4 && bus.i_opcode == 4'hF) m_halt = 1'b1;
      else m_step = (m_step == 6) ? 1 : m_step + 1;
    end
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op);
    bus.i_opcode = op;
    bus.i_run    = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
  endtask

  initial begin
    rst          = 1'b1;
    bus.i_debug  = 1'b0;
    bus.i_run    = 1'b0;
    bus.i_opcode = 4'h0;
    m_step       = 1;
    m_halt       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held: enables forced low, state T1.
    cyc();
    rst = 1'b0;

    // Idle at T1 with run low.
    for (int k = 0; k < 5; k++) cyc();

    run_instr(4'h0);   // LDA
    run_instr(4'h2);   // SUB
    run_instr(4'h1);   // ADD
    run_instr(4'hE);   // OUT
    run_instr(4'h7);   // undefined -> NOP

    // HLT: four steps to T4, then HALT, then run toggling with no effect.
    bus.i_opcode = 4'hF;
    for (int k = 0; k < 4; k++) cyc();
    for (int k = 0; k < 20; k++) begin
      bus.i_run    = k[0];
      bus.i_opcode = 4'($urandom_range(0, 15));
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.i_run = 1'b0;
    cyc();

    // ADD interrupted by reset during T5.
    bus.i_opcode = 4'h1;
    bus.i_run    = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.i_run = 1'b0;
    cyc();

    // Random opcode stream; opcode only changes between instructions.
    for (int k = 0; k < 400; k++) begin
      bus.i_run = ($urandom_range(0, 3) != 0);
      if (m_step == 1) bus.i_opcode = 4'($urandom_range(0, 15));
      rst = m_halt ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 60) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
- Control-sequencer for the SAP-1 datapath.
- A six-state ring (T1..T6) runs the fetch and execute phases.
- Decodes the 4-bit unbuffered opcode from the instruction register into the per-cycle control word that drives the PC, MAR, RAM, IR, accumulator, ALU, B and output registers.
- Owns run/halt status; sits between the instruction register's opcode output and every datapath enable.

Parameters:
- OP_LDA, 4'b0000, load accumulator from RAM[address]
- OP_ADD, 4'b0001, A <= A + RAM[address]
- OP_SUB, 4'b0010, A <= A - RAM[address]
- OP_OUT, 4'b1110, output register <= A
- OP_HLT, 4'b1111, stop sequencing

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_debug  in  1  enables $display trace of each state and decoded opcode
- i_run  in  1  1 = allow a new instruction to start at T1
- i_opcode  in  4  unbuffered opcode from instruction register
- o_cp  out  1  PC increment
- o_ep  out  1  PC drive bus
- o_lm  out  1  MAR load
- o_ce  out  1  RAM drive bus
- o_li  out  1  IR load
- o_ei  out  1  IR address drive bus (instruction register send enable)
- o_la  out  1  accumulator load
- o_ea  out  1  accumulator drive bus
- o_su  out  1  ALU subtract select
- o_eu  out  1  ALU drive bus
- o_lb  out  1  B register load
- o_lo  out  1  output register load
- o_state  out  3  current T-state, one of T1..T6 (1..6), or HALT (7)
- o_halted  out  1  1 while in HALT
- o_instr_done  out  1  one-cycle pulse in the final cycle (T6) of each completed instruction

Behaviour:
- Synchronous reset:
  - i_reset high at a rising edge -> state = T1, o_halted = 0.
  - While i_reset is high, all control outputs (o_cp..o_lo, o_instr_done) are forced 0 combinationally.
  - Reset mid-instruction abandons that instruction; no further enables are issued.
- All control outputs are active-high and combinational from (state, i_opcode). Each is valid for the whole cycle of its state.
- Datapath registers act on the rising edge that ends that state.
- Transitions:
  - T1 -> T2 only if i_run = 1. With i_run = 0 in T1, state holds at T1 and all control outputs are 0.
  - T2 -> T3 -> T4 -> T5 -> T6 -> T1 unconditionally.
  - i_run is ignored outside T1, so a started instruction always completes.
- Fetch (all opcodes):
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li. IR latches the opcode; i_opcode is stable from T4 onward.
- Execute:
  - LDA: T4 ei, lm; T5 ce, la; T6 none.
  - ADD: T4 ei, lm; T5 ce, lb; T6 eu, la (su = 0).
  - SUB: T4 ei, lm; T5 ce, lb; T6 eu, la, su.
  - OUT: T4 ea, lo; T5 none; T6 none.
  - Undefined opcode: T4-T6 none (NOP, 6 cycles).
- HLT:
  - In T4 with i_opcode = OP_HLT, no enables are issued; the next state is HALT.
  - HALT: all control outputs 0, o_halted = 1, o_instr_done never pulses.
  - HALT is left only by reset; i_run has no effect.
- Instruction length is fixed at 6 cycles, so PC advances exactly once per instruction, in T2.
- Bus exclusivity: at most one of ep, ce, ei, ea, eu is high in any cycle. The bench checks this as an invariant.
- o_instr_done = 1 in T6 for every non-HLT opcode.
- Debug: if i_debug = 1, print the state name and opcode on each transition, plus "CTRL halted" on HALT entry.

Decomposition:
- Shared package sap1_pkg:
  - opcode constants (OP_*), also used by the instruction-register testbench;
  - state encodings T1..T6 and HALT;
  - control-word bit indices, if bundling is wanted later.
- One natural sub-module, sap1_ring_counter: the state register with the run gate and HALT trap.
- Opcode decode stays in the top module as a single combinational case over state and opcode.

Test Plan:
- Reset, then i_run = 0 for 5 cycles -> o_state = 1 throughout, all enables 0, o_instr_done = 0.
- i_run = 1, i_opcode = 4'b0000 (LDA), sampled per cycle T1..T6:
  - T1 ep, lm; T2 cp; T3 ce, li; T4 ei, lm; T5 ce, la; T6 nothing asserted;
  - o_instr_done = 1 only in T6; state returns to 1.
- i_opcode = 4'b0010 (SUB) -> T6 shows eu = la = su = 1.
- Repeat with 4'b0001 (ADD) -> T6 su = 0.
- i_opcode = 4'b1110 (OUT) -> T4 ea = lo = 1; T5 and T6 all 0.
- i_opcode = 4'b1111 at T4 -> o_state = 7 and o_halted = 1 from the next cycle.
  - Hold 20 cycles with i_run toggling: no enable ever rises.
  - Assert i_reset for 1 cycle -> o_state = 1, o_halted = 0.
- Run ADD and assert i_reset in T5 -> no la or eu in the following cycle; o_state = 1 after the edge. Over a random opcode stream, never more than one bus driver per cycle.
